njp_mult_seq: RTL and testbench

Parametrised sequential shift-add multiplier core, the wide successor to the current micro multiplier. It sits behind the Tiny Tapeout top-level pin wrapper and computes one WIDTH×WIDTH product per request over WIDTH+1 cycles using a start/busy/done handshake. It adds a signed mode, an accumulate mode with sticky overflow, and stall via `ena`.

---
 rtl/njp_mult_pkg.sv | 14 +
 rtl/njp_mult_dp.sv | 106 ++++++++++
 rtl/njp_mult_seq.sv | 98 +++++++++
 tb/tb_njp_mult_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/njp_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package njp_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/njp_mult_dp.sv
// Datapath: operand magnitudes, shift-add partial product, sign fix-up and
// accumulate adder with sticky carry/signed overflow.
module njp_mult_dp
  import njp_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               clr,
  input  logic               signed_in,
  input  logic               acc_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf
);

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]    prod_q, prod_d;
  logic [RW-1:0]    result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             sign_q, sign_d;
  logic             acc_q, acc_d;
  logic             signed_q, signed_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [RW-1:0]    p;
  logic [RW:0]      sum;
  logic             sovf;

  // -2^(W-1) negates to itself, which read as unsigned is its exact magnitude
  assign a_mag = (signed_in && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (signed_in && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign p     = sign_q ? (~prod_q + 1'b1) : prod_q;
  assign sum   = {1'b0, result_q} + {1'b0, p};
  assign sovf  = (result_q[RW-1] == p[RW-1]) && (sum[RW-1] != result_q[RW-1]);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    signed_d = signed_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      prod_d   = '0;
      sign_d   = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = acc_in;
      signed_d = signed_in;
    end else if (clr) begin
      result_d = '0;
      ovf_d    = 1'b0;
    end
    if (step) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
    if (fix) begin
      if (acc_q) begin
        result_d = sum[RW-1:0];
        ovf_d    = ovf_q | (signed_q ? sovf : sum[RW]);
      end else begin
        result_d = p;
        ovf_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
      acc_q    <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      signed_q <= signed_d;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/njp_mult_seq.sv
// Sequential WIDTHxWIDTH multiplier: FSM, iteration counter and the
// start/busy/done handshake; ena low freezes everything.
module njp_mult_seq
  import njp_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               acc_mode,
  input  logic               clear,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic load, step, fix, clr;

  assign load = ena && (state_q == IDLE) && start;
  assign clr  = ena && (state_q == IDLE) && !start && clear;
  assign step = ena && (state_q == RUN);
  assign fix  = ena && (state_q == FIX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          done_d = 1'b0;
          if (start) begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  njp_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .clr       (clr),
    .signed_in (signed_mode),
    .acc_in    (acc_mode),
    .a         (a),
    .b         (b),
    .result    (result),
    .ovf       (ovf)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_njp_mult_seq.sv
// Directed-vector bench for njp_mult_seq at WIDTH=8 and WIDTH=16.
module tb_njp_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;

  logic        start8 = 1'b0, sgn8 = 1'b0, acc8 = 1'b0, clear8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, ovf8;
  logic [15:0] result8;

  logic        start16 = 1'b0, sgn16 = 1'b0, acc16 = 1'b0, clear16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, ovf16;
  logic [31:0] result16;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  njp_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start8), .signed_mode(sgn8),
    .acc_mode(acc8), .clear(clear8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .ovf(ovf8)
  );

  njp_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start16), .signed_mode(sgn16),
    .acc_mode(acc16), .clear(clear16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .ovf(ovf16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                               input logic sv, input logic accv,
                               input logic [15:0] expRes, input logic expOvf);
    int cyc;
    a8 = av; b8 = bv; sgn8 = sv; acc8 = accv; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy8), 32'd1);
    cyc = 0;
    while (!done8 && cyc < 40) begin
      tick(1);
      cyc++;
    end
    checkOutput({tag, "_lat"}, 32'(cyc), 32'd9);
    checkOutput({tag, "_res"}, 32'(result8), 32'(expRes));
    checkOutput({tag, "_ovf"}, 32'(ovf8), 32'(expOvf));
    checkOutput({tag, "_busy_end"}, 32'(busy8), 32'd0);
    tick(1);
    checkOutput({tag, "_done_clr"}, 32'(done8), 32'd0);
  endtask

  task automatic applyStimulus16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                                 input logic sv, input logic [31:0] expRes);
    int cyc;
    a16 = av; b16 = bv; sgn16 = sv; acc16 = 1'b0; start16 = 1'b1;
    tick(1);
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 60) begin
      tick(1);
      cyc++;
    end
    checkOutput({tag, "_lat"}, 32'(cyc), 32'd17);
    checkOutput({tag, "_res"}, result16, expRes);
    tick(1);
  endtask

  task automatic doClear(input string tag);
    clear8 = 1'b1;
    tick(1);
    clear8 = 1'b0;
    checkOutput({tag, "_res"}, 32'(result8), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(ovf8), 32'd0);
  endtask

  initial begin
    int cyc;
    int doneCnt;
    #12;
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_res", 32'(result8), 32'd0);
    checkOutput("rst_ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;
    tick(1);

    applyStimulus("u13x11", 8'd13, 8'd11, 1'b0, 1'b0, 16'd143, 1'b0);
    applyStimulus("s_m3x5", 8'hFD, 8'd5, 1'b1, 1'b0, 16'hFFF1, 1'b0);
    applyStimulus("s_80x80", 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 1'b0);
    applyStimulus("s_acc_ovf", 8'h80, 8'h80, 1'b1, 1'b1, 16'h8000, 1'b1);
    doClear("clr1");
    applyStimulus("u200x200", 8'd200, 8'd200, 1'b0, 1'b0, 16'h9C40, 1'b0);
    applyStimulus("u_acc_ovf", 8'd200, 8'd200, 1'b0, 1'b1, 16'h3880, 1'b1);
    doClear("clr2");

    // start re-pulsed mid-operation must be ignored
    a8 = 8'd7; b8 = 8'd9; sgn8 = 1'b0; acc8 = 1'b0; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    doneCnt = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3 || c == 5) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      tick(1);
      if (done8) doneCnt++;
    end
    start8 = 1'b0;
    checkOutput("repulse_dones", 32'(doneCnt), 32'd1);
    checkOutput("repulse_res", 32'(result8), 32'd63);

    // clear with start: start wins, accumulate onto 63
    clear8 = 1'b1;
    applyStimulus("clr_start", 8'd2, 8'd3, 1'b0, 1'b1, 16'd69, 1'b0);
    clear8 = 1'b0;

    // ena low for 4 cycles mid-RUN stretches latency to 13
    a8 = 8'd13; b8 = 8'd11; sgn8 = 1'b0; acc8 = 1'b0; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    tick(2);
    ena = 1'b0;
    tick(4);
    ena = 1'b1;
    cyc = 6;
    while (!done8 && cyc < 40) begin
      tick(1);
      cyc++;
    end
    checkOutput("stall_lat", 32'(cyc), 32'd13);
    checkOutput("stall_res", 32'(result8), 32'd143);
    ena = 1'b0;
    tick(2);
    checkOutput("stall_done_held", 32'(done8), 32'd1);
    ena = 1'b1;
    tick(1);
    checkOutput("stall_done_clr", 32'(done8), 32'd0);

    // asynchronous reset mid-RUN
    a8 = 8'd200; b8 = 8'd200; start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_done", 32'(done8), 32'd0);
    checkOutput("abort_res", 32'(result8), 32'd0);
    checkOutput("abort_ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (done8) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'd0);

    applyStimulus16("w16_uFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    applyStimulus16("w16_u1234x5678", 16'd1234, 16'd5678, 1'b0, 32'h006AE9BC);
    applyStimulus16("w16_s8000sq", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
    applyStimulus16("w16_sm1x2", 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
    applyStimulus16("w16_s7FFFx8000", 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
